// File: rtl/result_commit.sv
// Result commit stage: routes an accepted ALU result to the GPR file, the PC or a RAM store.
// Optional store acknowledge timeout is built when STORE_TIMEOUT_EN is defined.
module result_commit #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned REG_AW      = 4,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic              store_i,
  input  logic              branch_i,
  input  logic              writeback_i,
  input  logic [DATA_W-1:0] alu_bus_i,
  input  logic [REG_AW-1:0] rd_addr_i,
  input  logic [DATA_W-1:0] mem_addr_i,
  output logic              gpr_we_o,
  output logic [REG_AW-1:0] gpr_waddr_o,
  output logic [DATA_W-1:0] gpr_wdata_o,
  output logic              pc_load_o,
  output logic [DATA_W-1:0] pc_value_o,
  output logic              mem_req_o,
  output logic [DATA_W-1:0] mem_waddr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  output logic              commit_done_o,
  output logic              illegal_sel_o,
  output logic              store_timeout_o
);

  typedef enum logic [0:0] {StIdle, StStoreWait} state_e;

  state_e state_q, state_d;

  logic              gpr_we_q, gpr_we_d;
  logic [REG_AW-1:0] gpr_waddr_q, gpr_waddr_d;
  logic [DATA_W-1:0] gpr_wdata_q, gpr_wdata_d;
  logic              pc_load_q, pc_load_d;
  logic [DATA_W-1:0] pc_value_q, pc_value_d;
  logic              mem_req_q, mem_req_d;
  logic [DATA_W-1:0] mem_waddr_q, mem_waddr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              commit_done_q, commit_done_d;
  logic              illegal_sel_q, illegal_sel_d;

  logic       xfer;
  logic [2:0] sel;

`ifdef STORE_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYC - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            timeout_q, timeout_d;
`endif

  assign in_ready_o = (state_q == StIdle);
  assign xfer       = in_valid_i & in_ready_o;
  assign sel        = {store_i, branch_i, writeback_i};

  always_comb begin
    state_d       = state_q;
    gpr_we_d      = 1'b0;
    gpr_waddr_d   = gpr_waddr_q;
    gpr_wdata_d   = gpr_wdata_q;
    pc_load_d     = 1'b0;
    pc_value_d    = pc_value_q;
    mem_req_d     = mem_req_q;
    mem_waddr_d   = mem_waddr_q;
    mem_wdata_d   = mem_wdata_q;
    commit_done_d = 1'b0;
    illegal_sel_d = 1'b0;
`ifdef STORE_TIMEOUT_EN
    cnt_d         = cnt_q;
    timeout_d     = 1'b0;
`endif

    case (state_q)
      StIdle: begin
        if (xfer) begin
          unique case (sel)
            3'b001: begin
              gpr_we_d      = 1'b1;
              gpr_waddr_d   = rd_addr_i;
              gpr_wdata_d   = alu_bus_i;
              commit_done_d = 1'b1;
            end
            3'b010: begin
              pc_load_d     = 1'b1;
              pc_value_d    = alu_bus_i;
              commit_done_d = 1'b1;
            end
            3'b100: begin
              state_d     = StStoreWait;
              mem_req_d   = 1'b1;
              mem_waddr_d = mem_addr_i;
              mem_wdata_d = alu_bus_i;
`ifdef STORE_TIMEOUT_EN
              cnt_d       = '0;
`endif
            end
            default: illegal_sel_d = 1'b1;
          endcase
        end
      end
      StStoreWait: begin
        if (mem_req_q && mem_ack_i) begin
          state_d       = StIdle;
          mem_req_d     = 1'b0;
          commit_done_d = 1'b1;
`ifdef STORE_TIMEOUT_EN
        end else if (cnt_q == CntLast) begin
          // Acknowledge wins over a timeout landing on the same cycle.
          state_d   = StIdle;
          mem_req_d = 1'b0;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= StIdle;
      gpr_we_q      <= 1'b0;
      gpr_waddr_q   <= '0;
      gpr_wdata_q   <= '0;
      pc_load_q     <= 1'b0;
      pc_value_q    <= '0;
      mem_req_q     <= 1'b0;
      mem_waddr_q   <= '0;
      mem_wdata_q   <= '0;
      commit_done_q <= 1'b0;
      illegal_sel_q <= 1'b0;
`ifdef STORE_TIMEOUT_EN
      cnt_q         <= '0;
      timeout_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      gpr_we_q      <= gpr_we_d;
      gpr_waddr_q   <= gpr_waddr_d;
      gpr_wdata_q   <= gpr_wdata_d;
      pc_load_q     <= pc_load_d;
      pc_value_q    <= pc_value_d;
      mem_req_q     <= mem_req_d;
      mem_waddr_q   <= mem_waddr_d;
      mem_wdata_q   <= mem_wdata_d;
      commit_done_q <= commit_done_d;
      illegal_sel_q <= illegal_sel_d;
`ifdef STORE_TIMEOUT_EN
      cnt_q         <= cnt_d;
      timeout_q     <= timeout_d;
`endif
    end
  end

  assign gpr_we_o      = gpr_we_q;
  assign gpr_waddr_o   = gpr_waddr_q;
  assign gpr_wdata_o   = gpr_wdata_q;
  assign pc_load_o     = pc_load_q;
  assign pc_value_o    = pc_value_q;
  assign mem_req_o     = mem_req_q;
  assign mem_waddr_o   = mem_waddr_q;
  assign mem_wdata_o   = mem_wdata_q;
  assign commit_done_o = commit_done_q;
  assign illegal_sel_o = illegal_sel_q;

`ifdef STORE_TIMEOUT_EN
  assign store_timeout_o = timeout_q;
`else
  // TIMEOUT_CYC only matters with the timeout built; the output is constant 0 here.
  assign store_timeout_o = 1'b0 & (TIMEOUT_CYC != 0);
`endif

endmodule

// File: doc/result_commit.md
RESULT_COMMIT -- requirements
Module: result_commit

Interface
REQ-001 Parameter DATA_W, default 32, width of the ALU result and memory data/address paths.
REQ-002 Parameter REG_AW, default 4, width of the GPR write address.
REQ-003 Parameter TIMEOUT_CYC, default 255, maximum number of cycles a store waits for acknowledge; used only when STORE_TIMEOUT_EN is defined.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  upstream result present.
REQ-007 in_ready  output  1  block can accept a result this cycle.
REQ-008 store, branch, writeback  input  1 each  destination select from the decoder; legal only when exactly one is high.
REQ-009 alu_bus  input  DATA_W  ALU result to commit.
REQ-010 rd_addr  input  REG_AW  GPR destination index.
REQ-011 mem_addr  input  DATA_W  RAM destination address for stores.
REQ-012 gpr_we, gpr_waddr, gpr_wdata  output  1/REG_AW/DATA_W  register-file write port.
REQ-013 pc_load, pc_value  output  1/DATA_W  program-counter load port.
REQ-014 mem_req, mem_waddr, mem_wdata  output  1/DATA_W/DATA_W  RAM write request.
REQ-015 mem_ack  input  1  RAM has taken the write.
REQ-016 commit_done  output  1  one-cycle pulse per completed commit.
REQ-017 illegal_sel  output  1  one-cycle pulse when a malformed select is accepted.
REQ-018 store_timeout  output  1  one-cycle pulse when a store is aborted (STORE_TIMEOUT_EN only; tied 0 otherwise).

Function
REQ-019 The FSM SHALL have exactly two states: IDLE and STORE_WAIT.
REQ-020 in_ready SHALL be 1 in IDLE and 0 in STORE_WAIT; a transfer occurs when in_valid and in_ready are high at a rising edge.
REQ-021 Writeback transfer: in the next cycle gpr_we=1, gpr_waddr=rd_addr, gpr_wdata=alu_bus (as captured), commit_done=1, all for exactly one cycle; the FSM stays in IDLE.
REQ-022 Branch transfer: in the next cycle pc_load=1, pc_value=alu_bus, commit_done=1, for one cycle; the FSM stays in IDLE.
REQ-023 Back-to-back writeback/branch transfers SHALL be accepted on consecutive cycles, giving one commit per cycle.
REQ-024 Store transfer: the FSM enters STORE_WAIT; from the next cycle mem_req=1 with mem_waddr=mem_addr and mem_wdata=alu_bus held stable until mem_ack is sampled high.
REQ-025 On the edge where mem_req and mem_ack are both high, the FSM SHALL return to IDLE, and in the following cycle mem_req=0 and commit_done=1.
REQ-026 A mem_ack arriving on the same edge as the first mem_req cycle SHALL complete the store, for a minimum store latency of 2 cycles from transfer to commit_done.
REQ-027 mem_ack SHALL be ignored while mem_req is 0.
REQ-028 A transfer with select 000 or more than one select high SHALL produce no write, no load and no request; illegal_sel pulses for one cycle the next cycle; the FSM stays in IDLE.
REQ-029 gpr_wdata, pc_value, mem_wdata and the address outputs SHALL retain their last value when their strobe is low; only the strobes qualify them.
REQ-030 At most one of gpr_we, pc_load and a new mem_req assertion SHALL rise in any cycle.

Reset
REQ-031 With rst high at a rising edge, the FSM SHALL go to IDLE and all outputs except in_ready SHALL be 0 in the following cycle; in_ready SHALL be 1.
REQ-032 Reset during STORE_WAIT SHALL drop mem_req on the next cycle without a commit_done pulse; the pending store is discarded.
REQ-033 A transfer presented in the same cycle as rst high SHALL be discarded.

Configuration
REQ-034 Macro STORE_TIMEOUT_EN: when defined, a counter SHALL clear on entry to STORE_WAIT and count each STORE_WAIT cycle without acknowledge; when it reaches TIMEOUT_CYC, mem_req SHALL drop, the FSM SHALL return to IDLE, and store_timeout SHALL pulse for one cycle with no commit_done.
REQ-035 When STORE_TIMEOUT_EN is undefined, no counter SHALL be built, STORE_WAIT SHALL wait indefinitely, and store_timeout SHALL be constant 0.

Verification
REQ-036 Writeback, rd_addr=5, alu_bus=0xDEADBEEF -> next cycle gpr_we=1, gpr_waddr=5, gpr_wdata=0xDEADBEEF, commit_done=1; the cycle after, gpr_we=0.
REQ-037 Branch with alu_bus=0x00000040, then writeback the following cycle -> pc_load pulse with 0x40, then gpr_we pulse; in_ready stays 1 throughout.
REQ-038 Store, mem_addr=0x100, alu_bus=0x12345678, mem_ack held 0 for 3 cycles then 1 -> mem_req high for 4 cycles; in_ready=0 during STORE_WAIT; commit_done pulses one cycle after the ack.
REQ-039 select 011 with in_valid=1 -> illegal_sel pulses; gpr_we, pc_load and mem_req all remain 0.
REQ-040 rst asserted during the 2nd cycle of STORE_WAIT -> mem_req=0 and in_ready=1 the next cycle; no commit_done.
REQ-041 With STORE_TIMEOUT_EN defined and TIMEOUT_CYC=4, a store with mem_ack tied 0 -> mem_req high for 4 cycles, then store_timeout pulses and in_ready returns to 1.
